// File: rtl/rv_adc_if.sv
// rv_adc_if -- memory-mapped XADC result registers for the rv32 peripheral bus.
//
// A DRP master first writes the XADC sequencer configuration. It then polls the
// nine status channels round-robin and caches each 12-bit result. The CPU reads
// the cached results as read-only registers. Channel 0 (die temperature) is also
// driven out as device_temp for the memory controller.
//
// Ports:
//   clk, xreset        bus clock (also clocks the DRP interface), async active-low reset
//   adr, cs, re, we, dw  bus request; writes are accepted but have no effect
//   rdy                bus ready, always 1
//   dr                 registered read data, updated on cs&re edges
//   drp_*              DRP master port to the XADC primitive
//   device_temp        latest cached temperature code
//
// Register map (word addresses):
//   0..8   cached results drp_do[15:4]: temp, vccint, vccaux, vaux1, vaux2,
//          vaux4, vaux5, vaux9, vaux10
//   9      {err(sticky), 15'b0, completed poll rounds}
//   10..31 read as zero
module rv_adc_if #(
  parameter int unsigned POLL_GAP    = 64,
  parameter int unsigned DRP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  output logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [11:0] device_temp
);

  localparam int unsigned NCH = 9;

  typedef enum logic [2:0] {
    S_INIT0,
    S_INIT1,
    S_INIT2,
    S_GAP,
    S_RD,
    S_WAIT,
    S_STORE
  } state_e;

  // DRP address of each cached channel, in polling order.
  function automatic logic [6:0] chan_addr(input logic [3:0] k);
    unique case (k)
      4'd0:    return 7'h00;
      4'd1:    return 7'h01;
      4'd2:    return 7'h02;
      4'd3:    return 7'h11;
      4'd4:    return 7'h12;
      4'd5:    return 7'h14;
      4'd6:    return 7'h15;
      4'd7:    return 7'h19;
      default: return 7'h1A;
    endcase
  endfunction

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;          // where WAIT goes once the access ends
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] round_q, round_d;
  logic        err_q, err_d;
  logic        ok_q, ok_d;            // last access completed (not timed out)
  logic [11:0] rdata_q, rdata_d;
  logic [11:0] cache_q [NCH];
  logic [11:0] cache_d [NCH];
  logic [6:0]  daddr_q, daddr_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [15:0] di_q, di_d;
  logic [31:0] dr_q, dr_d;
  logic [31:0] rd_val;

  // Bus write data/strobes and the low result nibble carry no information here.
  logic unused_bus;
  assign unused_bus = ^{we, dw, drp_do[3:0]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned -- that is what keeps this block free of latches.
    state_d   = state_q;
    ret_d     = ret_q;
    gap_cnt_d = '0;
    tmo_cnt_d = '0;
    k_d       = k_q;
    round_d   = round_q;
    err_d     = err_q;
    ok_d      = ok_q;
    rdata_d   = rdata_q;
    cache_d   = cache_q;
    daddr_d   = daddr_q;
    den_d     = 1'b0;
    dwe_d     = dwe_q;
    di_d      = di_q;

    unique case (state_q)
      S_INIT0: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        daddr_d = 7'h41;
        di_d    = 16'h2000;          // continuous sequence mode
        ret_d   = S_INIT1;
        state_d = S_WAIT;
      end
      S_INIT1: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        daddr_d = 7'h48;
        di_d    = 16'h0701;          // temp, vccint, vccaux, calibration
        ret_d   = S_INIT2;
        state_d = S_WAIT;
      end
      S_INIT2: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        daddr_d = 7'h49;
        di_d    = 16'h0636;          // vaux 1, 2, 4, 5, 9, 10
        ret_d   = S_GAP;
        state_d = S_WAIT;
      end
      S_GAP: begin
        if (gap_cnt_q == 16'(POLL_GAP - 1)) state_d = S_RD;
        else                                gap_cnt_d = gap_cnt_q + 16'd1;
      end
      S_RD: begin
        den_d   = 1'b1;
        dwe_d   = 1'b0;
        daddr_d = chan_addr(k_q);
        di_d    = '0;
        ret_d   = S_STORE;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy) begin
          ok_d    = 1'b1;
          rdata_d = drp_do[15:4];
          state_d = ret_q;
        end else if (tmo_cnt_q == 16'(DRP_TIMEOUT - 1)) begin
          // Abandon the access but carry on as if it had completed.
          ok_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ret_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_STORE: begin
        if (ok_q) cache_d[k_q] = rdata_q;
        if (k_q == 4'(NCH - 1)) begin
          k_d     = '0;
          round_d = round_q + 16'd1;
        end else begin
          k_d = k_q + 4'd1;
        end
        state_d = S_GAP;
      end
      default: state_d = S_INIT0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (adr < 5'd9)       rd_val = {20'b0, cache_q[adr[3:0]]};
    else if (adr == 5'd9) rd_val = {err_q, 15'b0, round_q};
    dr_d = (cs && re) ? rd_val : dr_q;
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q   <= S_INIT0;
      ret_q     <= S_INIT1;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
      k_q       <= '0;
      round_q   <= '0;
      err_q     <= 1'b0;
      ok_q      <= 1'b0;
      rdata_q   <= '0;
      // NOTE: the cache is a handful of flops that software may read straight
      // after reset, so it is reset like any other register, not left as RAM.
      for (int i = 0; i < NCH; i++) cache_q[i] <= '0;
      daddr_q   <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      dr_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      ret_q     <= ret_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      k_q       <= k_d;
      round_q   <= round_d;
      err_q     <= err_d;
      ok_q      <= ok_d;
      rdata_q   <= rdata_d;
      cache_q   <= cache_d;
      daddr_q   <= daddr_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      di_q      <= di_d;
      dr_q      <= dr_d;
    end
  end

  assign rdy         = 1'b1;
  assign dr          = dr_q;
  assign drp_daddr   = daddr_q;
  assign drp_den     = den_q;
  assign drp_dwe     = dwe_q;
  assign drp_di      = di_q;
  assign device_temp = cache_q[0];

endmodule

// File: tb/tb_rv_adc_if.sv
// tb_rv_adc_if -- self-checking bench for rv_adc_if.
//
// An XADC DRP responder answers each access a few cycles after den and logs
// every access. A reference of the register file is kept as "value before /
// value after / first read edge that sees the new value", derived from when
// the responder returned data: the result is captured on the drdy edge,
// written one edge later, and visible to bus reads from the edge after that.
module tb_rv_adc_if;

  localparam int unsigned POLL_GAP    = 64;
  localparam int unsigned DRP_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        xreset;
  logic [4:0]  adr;
  logic        cs;
  logic        rdy;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic [31:0] dr;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [11:0] device_temp;

  rv_adc_if #(.POLL_GAP(POLL_GAP), .DRP_TIMEOUT(DRP_TIMEOUT)) dut (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we),
    .re(re), .dw(dw), .dr(dr), .drp_daddr(drp_daddr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do),
    .drp_drdy(drp_drdy), .device_temp(device_temp)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- DRP responder and access log ----------------
  typedef struct {
    logic [6:0]  addr;
    logic        wr;
    logic [15:0] di;
    int          at;
  } acc_t;

  acc_t        log_q[$];
  bit          busy = 1'b0;
  int          lat_cnt;
  logic [6:0]  pend_addr;
  logic        pend_wr;
  logic [15:0] rsp;
  bit          prev_den = 1'b0;
  bit          rand_mode = 1'b0;
  bit          temp_override = 1'b0;
  bit          drop_en = 1'b0;
  logic [6:0]  drop_addr = 7'h12;

  logic [31:0] ref_old [16];
  logic [31:0] ref_new [16];
  int          ref_at  [16];

  function automatic int reg_of(input logic [6:0] a);
    case (a)
      7'h00: return 0;
      7'h01: return 1;
      7'h02: return 2;
      7'h11: return 3;
      7'h12: return 4;
      7'h14: return 5;
      7'h15: return 6;
      7'h19: return 7;
      7'h1A: return 8;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_val(input int i, input int e);
    if (i < 0 || i > 9) return 32'h0;
    return (e >= ref_at[i]) ? ref_new[i] : ref_old[i];
  endfunction

  task automatic ref_update(input int i, input logic [31:0] v, input int at);
    ref_old[i] = ref_new[i];
    ref_new[i] = v;
    ref_at[i]  = at;
  endtask

  function automatic acc_t log_at(input int i);
    acc_t e;
    e = '{addr: 7'h7F, wr: 1'bx, di: 16'hxxxx, at: -1};
    if (i >= 0 && i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  initial begin
    drp_do   = 16'h0;
    drp_drdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_old[i] = '0; ref_new[i] = '0; ref_at[i] = 0;
    end
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (xreset !== 1'b1) begin
        busy     = 1'b0;
        prev_den = 1'b0;
        for (int i = 0; i < 16; i++) begin
          ref_old[i] = '0; ref_new[i] = '0; ref_at[i] = 0;
        end
      end else begin
        if (busy) begin
          if (lat_cnt == 0) begin
            int r;
            busy     = 1'b0;
            drp_drdy = 1'b1;
            drp_do   = rsp;
            r = reg_of(pend_addr);
            if (!pend_wr && r >= 0) begin
              ref_update(r, {20'h0, rsp[15:4]}, cyc + 3);
              if (r == 8) ref_update(9, (ref_new[9] + 32'd1) & 32'hFFFF, cyc + 3);
            end
          end else begin
            lat_cnt--;
          end
        end
        if (drp_den === 1'b1) begin
          check("den_single_cycle", {31'h0, prev_den}, 32'h0);
          log_q.push_back('{addr: drp_daddr, wr: drp_dwe, di: drp_di, at: cyc});
          if (!(drop_en && drp_daddr == drop_addr)) begin
            busy      = 1'b1;
            lat_cnt   = 2;
            pend_addr = drp_daddr;
            pend_wr   = drp_dwe;
            if (rand_mode)                              rsp = 16'($urandom);
            else if (temp_override && drp_daddr == 7'h00) rsp = 16'hABC0;
            else                                        rsp = {1'b0, drp_daddr, 8'h00};
          end
        end
        prev_den = (drp_den === 1'b1);
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    adr = a; cs = 1'b1; re = 1'b1;
    we  = 4'($urandom); dw = $urandom;  // writes must be ignored
    @(negedge clk);
    cs = 1'b0; re = 1'b0; we = 4'h0;
    d = dr;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int b;
    b = budget;
    while (log_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rdy"},   32'(rdy),         32'd1);
    check({pfx, "_dr"},    dr,               32'd0);
    check({pfx, "_temp"},  32'(device_temp), 32'd0);
    check({pfx, "_den"},   32'(drp_den),     32'd0);
    check({pfx, "_dwe"},   32'(drp_dwe),     32'd0);
    check({pfx, "_daddr"}, 32'(drp_daddr),   32'd0);
    check({pfx, "_di"},    32'(drp_di),      32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] e;
    logic [6:0]  chan [9];
    acc_t        ac;
    acc_t        an;
    int          idx;
    int          start;
    int          b;
    int          n;
    int          a;

    chan = '{7'h00, 7'h01, 7'h02, 7'h11, 7'h12, 7'h14, 7'h15, 7'h19, 7'h1A};
    adr = '0; cs = 1'b0; re = 1'b0; we = '0; dw = '0;
    xreset = 1'b1;
    #2 xreset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    xreset = 1'b1;

    // Configuration writes, in order.
    wait_log(3, 300, "init_writes_seen");
    ac = log_at(0);
    check("init0_addr", 32'(ac.addr), 32'h41);
    check("init0_we",   32'(ac.wr),   32'd1);
    check("init0_di",   32'(ac.di),   32'h2000);
    ac = log_at(1);
    check("init1_addr", 32'(ac.addr), 32'h48);
    check("init1_we",   32'(ac.wr),   32'd1);
    check("init1_di",   32'(ac.di),   32'h0701);
    ac = log_at(2);
    check("init2_addr", 32'(ac.addr), 32'h49);
    check("init2_we",   32'(ac.wr),   32'd1);
    check("init2_di",   32'(ac.di),   32'h0636);

    // One full polling round plus the start of the next one.
    wait_log(13, 2000, "first_round_seen");
    for (int i = 0; i < 10; i++) begin
      ac = log_at(3 + i);
      check($sformatf("poll%0d_addr", i), 32'(ac.addr), 32'(chan[i % 9]));
      check($sformatf("poll%0d_we", i),   32'(ac.wr),   32'd0);
    end

    bus_read(5'd3, d); check("round1_reg3", d, 32'h110);
    bus_read(5'd8, d); check("round1_reg8", d, 32'h1A0);
    bus_read(5'd9, d); check("round1_reg9", d, 32'h1);
    bus_read(5'd0, d); check("round1_reg0", d, 32'h0);
    check("round1_temp", 32'(device_temp), 32'h0);

    // Temperature channel returns 0xABC0.
    n = log_q.size();
    temp_override = 1'b1;
    wait_log(n + 10, 2000, "temp_round_seen");
    bus_read(5'd0, d); check("temp_reg0", d, 32'hABC);
    check("temp_out", 32'(device_temp), 32'hABC);
    check("temp_rdy", 32'(rdy), 32'd1);

    // Random data, CPU reads four cycles apart.
    rand_mode = 1'b1;
    for (int i = 0; i < 700; i++) begin
      a = int'($urandom_range(0, 15));
      bus_read(5'(a), d);
      check($sformatf("rand_read%0d_a%0d", i, a), d, ref_val(a, cyc));
      check("rand_rdy", 32'(rdy), 32'd1);
      check("rand_temp", 32'(device_temp), ref_val(0, cyc + 1));
      repeat (2) @(negedge clk);
    end

    // vaux2 (0x12) never answers: timeout, err, keep old value, move on.
    start   = log_q.size();
    drop_en = 1'b1;
    idx = -1;
    b   = 3000;
    while (idx < 0 && b > 0) begin
      @(negedge clk);
      b--;
      for (int i = start; i + 1 < log_q.size(); i++) begin
        if (log_q[i].addr == 7'h12 && !log_q[i].wr) begin
          idx = i;
          break;
        end
      end
    end
    check("drop_seen", 32'(idx >= 0), 32'd1);
    if (idx >= 0) begin
      ac = log_at(idx);
      an = log_at(idx + 1);
      check("drop_next_addr", 32'(an.addr), 32'h14);
      check("drop_delay_min", 32'((an.at - ac.at) >= int'(DRP_TIMEOUT + POLL_GAP)), 32'd1);
      check("drop_delay_max", 32'((an.at - ac.at) <= int'(DRP_TIMEOUT + POLL_GAP + 8)), 32'd1);
      bus_read(5'd9, d);
      e = ref_val(9, cyc);
      check("drop_err", 32'(d[31]), 32'd1);
      check("drop_count", 32'(d[15:0]), 32'(e[15:0]));
      bus_read(5'd4, d);
      check("drop_reg4_kept", d, ref_val(4, cyc));
    end
    drop_en = 1'b0;

    // Reset while an access is outstanding.
    b = 2000;
    while (!busy && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("midwait_reached", 32'(busy), 32'd1);
    xreset = 1'b0;
    #1;
    check_reset_outputs("midwait");
    log_q.delete();
    repeat (2) @(negedge clk);
    xreset = 1'b1;
    wait_log(3, 300, "restart_writes_seen");
    ac = log_at(0);
    check("restart0_addr", 32'(ac.addr), 32'h41);
    check("restart0_di",   32'(ac.di),   32'h2000);
    ac = log_at(2);
    check("restart2_addr", 32'(ac.addr), 32'h49);
    bus_read(5'd9, d); check("restart_reg9", d, 32'h0);
    bus_read(5'd0, d); check("restart_reg0", d, 32'h0);
    check("restart_temp", 32'(device_temp), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
